ping_scheduler: RTL and testbench

Sequences one sonar measurement ("ping") at a time: it opens the transmit burst window, blanks the receiver during transducer ring-down, opens the listen window, timestamps the first echo, and steps the beam angle after each ping. It sits between the user enable and the transmit beamformer, receive beamformer, echo comparator, time-of-flight conversion and display logic. It owns the single shared emission timebase for all of those blocks.

---
 rtl/sonar_pkg.sv | 18 +
 rtl/ping_timer.sv | 48 ++++
 rtl/ping_scheduler.sv | 141 ++++++++++++++
 tb/tb_ping_scheduler.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// Shared sonar definitions. The ping state type and the default emission
// timebase live here, so the scheduler and the time-of-flight logic agree on
// one set of numbers.
package sonar_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BURST  = 3'd1,
    BLANK  = 3'd2,
    LISTEN = 3'd3,
    WAIT   = 3'd4
  } ping_state_t;

  localparam int unsigned PERIOD_CYCLES = 16777216;
  localparam int unsigned BURST_CYCLES  = 524288;
  localparam int unsigned BLANK_CYCLES  = 65536;

endpackage

// File: rtl/ping_timer.sv
// Ping timebase: a T_W-bit up-counter with synchronous clear, plus the
// terminal-count flags that mark the last burst, last blank and last period
// cycle.
// Ports:
//   clk_in, rst_in      clock, synchronous active-high reset
//   clr_in              force the count to 0 on the next edge
//   en_in               count up by one on the next edge
//   count_out           current count (cycles since burst start)
//   burst_end_out       count == BURST_CYCLES-1
//   blank_end_out       count == BURST_CYCLES+BLANK_CYCLES-1
//   period_end_out      count == PERIOD_CYCLES-1
module ping_timer #(
  parameter int unsigned BURST_CYCLES  = sonar_pkg::BURST_CYCLES,
  parameter int unsigned BLANK_CYCLES  = sonar_pkg::BLANK_CYCLES,
  parameter int unsigned PERIOD_CYCLES = sonar_pkg::PERIOD_CYCLES,
  parameter int unsigned T_W           = $clog2(PERIOD_CYCLES)
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           clr_in,
  input  logic           en_in,
  output logic [T_W-1:0] count_out,
  output logic           burst_end_out,
  output logic           blank_end_out,
  output logic           period_end_out
);

  localparam logic [T_W-1:0] BURST_LAST  = T_W'(BURST_CYCLES - 1);
  localparam logic [T_W-1:0] BLANK_LAST  = T_W'(BURST_CYCLES + BLANK_CYCLES - 1);
  localparam logic [T_W-1:0] PERIOD_LAST = T_W'(PERIOD_CYCLES - 1);

  logic [T_W-1:0] r_count;

  // The scheduler clears the count at every ping end, so it never wraps.
  always_ff @(posedge clk_in) begin
    if (rst_in || clr_in) begin
      r_count <= '0;
    end else if (en_in) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count_out      = r_count;
  assign burst_end_out  = (r_count == BURST_LAST);
  assign blank_end_out  = (r_count == BLANK_LAST);
  assign period_end_out = (r_count == PERIOD_LAST);

endmodule

// File: rtl/ping_scheduler.sv
// Sonar ping sequencer: burst window, receiver blanking, listen window with
// first-echo timestamp, then a wait to the period end. The beam angle steps
// after every ping. It owns the shared emission timebase (time_out).
// Ports:
//   clk_in, rst_in       clock, synchronous active-high reset
//   enable_in            request continuous pinging
//   echo_in              thresholded echo detect
//   burst_start_out      pulse on the first cycle of each ping
//   tx_en_out            burst window
//   rx_en_out            listen window (closes on capture)
//   busy_out             any state but IDLE
//   angle_out            beam index, wraps at ANGLE_STEPS
//   time_out             cycles since burst start
//   echo_time_out        timestamp of the last captured echo
//   echo_valid_out       pulse when echo_time_out updates
//   no_echo_out          pulse when a ping ends without a capture
module ping_scheduler #(
  parameter int unsigned BURST_CYCLES  = sonar_pkg::BURST_CYCLES,
  parameter int unsigned BLANK_CYCLES  = sonar_pkg::BLANK_CYCLES,
  parameter int unsigned PERIOD_CYCLES = sonar_pkg::PERIOD_CYCLES,
  parameter int unsigned ANGLE_STEPS   = 8,
  parameter int unsigned ANGLE_W       = 3,
  localparam int unsigned T_W          = $clog2(PERIOD_CYCLES)
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               enable_in,
  input  logic               echo_in,
  output logic               burst_start_out,
  output logic               tx_en_out,
  output logic               rx_en_out,
  output logic               busy_out,
  output logic [ANGLE_W-1:0] angle_out,
  output logic [T_W-1:0]     time_out,
  output logic [T_W-1:0]     echo_time_out,
  output logic               echo_valid_out,
  output logic               no_echo_out
);

  import sonar_pkg::*;

  generate
    if (BURST_CYCLES + BLANK_CYCLES >= PERIOD_CYCLES) begin : g_bad_timing
      $error("ping_scheduler: burst plus blank must be shorter than the period");
    end
    if (ANGLE_STEPS > (2 ** ANGLE_W)) begin : g_bad_angle
      $error("ping_scheduler: ANGLE_STEPS does not fit in ANGLE_W bits");
    end
  endgenerate

  localparam logic [ANGLE_W-1:0] ANGLE_LAST = ANGLE_W'(ANGLE_STEPS - 1);

  ping_state_t        r_state;
  ping_state_t        w_state_nxt;
  logic               r_burst_start;
  logic               r_echo_valid;
  logic               r_no_echo;
  logic [ANGLE_W-1:0] r_angle;
  logic [T_W-1:0]     r_echo_time;

  logic [T_W-1:0]     w_t;
  logic               w_burst_end;
  logic               w_blank_end;
  logic               w_period_end;
  logic               w_start;
  logic               w_ping_end;
  logic               w_echo_hit;

  assign w_start    = (r_state == IDLE) && enable_in;
  assign w_ping_end = ((r_state == LISTEN) || (r_state == WAIT)) && w_period_end;
  // Only LISTEN qualifies an echo; once captured the state leaves LISTEN,
  // which makes the first qualifying cycle the only one per ping.
  assign w_echo_hit = (r_state == LISTEN) && echo_in;

  ping_timer #(
    .BURST_CYCLES  (BURST_CYCLES),
    .BLANK_CYCLES  (BLANK_CYCLES),
    .PERIOD_CYCLES (PERIOD_CYCLES),
    .T_W           (T_W)
  ) u_timer (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .clr_in         (w_start || w_ping_end),
    .en_in          (r_state != IDLE),
    .count_out      (w_t),
    .burst_end_out  (w_burst_end),
    .blank_end_out  (w_blank_end),
    .period_end_out (w_period_end)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (enable_in) w_state_nxt = BURST;
      BURST:  if (w_burst_end) w_state_nxt = BLANK;
      BLANK:  if (w_blank_end) w_state_nxt = LISTEN;
      // Period end outranks the echo; the echo is still captured below.
      LISTEN: begin
        if (w_period_end)  w_state_nxt = enable_in ? BURST : IDLE;
        else if (echo_in)  w_state_nxt = WAIT;
      end
      WAIT:   if (w_period_end) w_state_nxt = enable_in ? BURST : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state       <= IDLE;
      r_burst_start <= 1'b0;
      r_echo_valid  <= 1'b0;
      r_no_echo     <= 1'b0;
      r_angle       <= '0;
      r_echo_time   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_burst_start <= w_start || (w_ping_end && enable_in);
      r_echo_valid  <= w_echo_hit;
      // Ending in WAIT means a capture happened; ending in LISTEN with an
      // echo on the final cycle also counts as a capture.
      r_no_echo     <= w_ping_end && (r_state == LISTEN) && !echo_in;
      if (w_echo_hit) begin
        r_echo_time <= w_t;
      end
      if (w_ping_end) begin
        r_angle <= (r_angle == ANGLE_LAST) ? '0 : r_angle + 1'b1;
      end
    end
  end

  assign burst_start_out = r_burst_start;
  assign tx_en_out       = (r_state == BURST);
  assign rx_en_out       = (r_state == LISTEN);
  assign busy_out        = (r_state != IDLE);
  assign angle_out       = r_angle;
  assign time_out        = w_t;
  assign echo_time_out   = r_echo_time;
  assign echo_valid_out  = r_echo_valid;
  assign no_echo_out     = r_no_echo;

endmodule

// File: tb/tb_ping_scheduler.sv
module tb_ping_scheduler;

  localparam int unsigned B     = 4;
  localparam int unsigned BL    = 3;
  localparam int unsigned P     = 20;
  localparam int unsigned STEPS = 3;
  localparam int unsigned AW    = 2;
  localparam int unsigned TW    = $clog2(P);

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          enable_in = 1'b0;
  logic          echo_in = 1'b0;
  logic          burst_start_out;
  logic          tx_en_out;
  logic          rx_en_out;
  logic          busy_out;
  logic [AW-1:0] angle_out;
  logic [TW-1:0] time_out;
  logic [TW-1:0] echo_time_out;
  logic          echo_valid_out;
  logic          no_echo_out;

  ping_scheduler #(
    .BURST_CYCLES  (B),
    .BLANK_CYCLES  (BL),
    .PERIOD_CYCLES (P),
    .ANGLE_STEPS   (STEPS),
    .ANGLE_W       (AW)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .enable_in       (enable_in),
    .echo_in         (echo_in),
    .burst_start_out (burst_start_out),
    .tx_en_out       (tx_en_out),
    .rx_en_out       (rx_en_out),
    .busy_out        (busy_out),
    .angle_out       (angle_out),
    .time_out        (time_out),
    .echo_time_out   (echo_time_out),
    .echo_valid_out  (echo_valid_out),
    .no_echo_out     (no_echo_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int last_bs  = -1;
  bit track_gap = 1'b0;

  // Reference model: a ping is "active" with an elapsed time t; the phase is
  // read straight from t (burst, blank, listen) and whether an echo was taken.
  bit m_active = 1'b0;
  int m_t      = 0;
  bit m_cap    = 1'b0;
  int m_angle  = 0;
  int m_etime  = 0;
  bit m_bs     = 1'b0;
  bit m_ev     = 1'b0;
  bit m_noe    = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model(input bit r, input bit e, input bit ec);
    bit listening;
    m_bs = 1'b0; m_ev = 1'b0; m_noe = 1'b0;
    if (r) begin
      m_active = 1'b0; m_t = 0; m_cap = 1'b0; m_angle = 0; m_etime = 0;
    end else if (!m_active) begin
      if (e) begin
        m_active = 1'b1; m_t = 0; m_cap = 1'b0; m_bs = 1'b1;
      end
    end else begin
      listening = (m_t >= int'(B + BL)) && !m_cap;
      if (listening && ec) begin
        m_cap = 1'b1; m_etime = m_t; m_ev = 1'b1;
      end
      if (m_t == int'(P) - 1) begin
        m_noe   = !m_cap;
        m_angle = (m_angle + 1) % STEPS;
        m_t     = 0;
        m_cap   = 1'b0;
        if (e) m_bs = 1'b1;
        else   m_active = 1'b0;
      end else begin
        m_t++;
      end
    end
  endtask

  task automatic step(input bit r, input bit e, input bit ec);
    rst_in = r; enable_in = e; echo_in = ec;
    @(posedge clk_in);
    model(r, e, ec);
    #1;
    cyc++;
    chk("burst_start", int'(burst_start_out), int'(m_bs));
    chk("tx_en",       int'(tx_en_out),       int'(m_active && m_t < int'(B)));
    chk("rx_en",       int'(rx_en_out),       int'(m_active && m_t >= int'(B + BL) && !m_cap));
    chk("busy",        int'(busy_out),        int'(m_active));
    chk("angle",       int'(angle_out),       m_angle);
    chk("time",        int'(time_out),        m_t);
    chk("echo_time",   int'(echo_time_out),   m_etime);
    chk("echo_valid",  int'(echo_valid_out),  int'(m_ev));
    chk("no_echo",     int'(no_echo_out),     int'(m_noe));
    if (burst_start_out) begin
      if (track_gap && last_bs >= 0) chk("bs_gap", cyc - last_bs, int'(P));
      last_bs = cyc;
    end
  endtask

  initial begin
    int guard;
    // Reset
    step(1, 0, 0);
    step(1, 0, 0);
    // 1: plain ping, no echo, into the start of the next one
    for (int i = 0; i < 22; i++) step(0, 1, 0);
    // 2: echo at t=10
    for (int i = 0; i < 40; i++) step(0, 1, m_t == 10);
    // 3: echo during burst/blank only
    for (int i = 0; i < 40; i++) step(0, 1, m_t <= 6);
    // Echo on the final period cycle wins over no-echo
    for (int i = 0; i < 40; i++) step(0, 1, m_t == int'(P) - 1);
    // 4: consecutive pings, burst pulses exactly P apart
    track_gap = 1'b1; last_bs = -1;
    for (int i = 0; i < 85; i++) step(0, 1, 0);
    track_gap = 1'b0;
    // 5: drop enable at t=5, ping completes, then idle
    guard = 0;
    while (m_t != 5 && guard < 60) begin step(0, 1, 0); guard++; end
    chk("reach_t5", m_t, 5);
    for (int i = 0; i < 30; i++) step(0, 0, (i % 4) == 0);
    // 6: reset at t=9 mid-listen, then restart
    guard = 0;
    while (m_t != 9 && guard < 60) begin step(0, 1, 0); guard++; end
    chk("reach_t9", m_t, 9);
    step(1, 1, 1);
    for (int i = 0; i < 25; i++) step(0, 1, m_t == 12);
    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 19) != 0),
           ($urandom_range(0, 9) == 0));
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
